// File: rtl/serial_word_deserializer.sv
// serial_word_deserializer: collects single bits into a word and holds it on a registered valid/ready port.
// An in_last bit ends the word early, and the positions that were never written stay zero.
module serial_word_deserializer #(
    parameter int DATA_WIDTH = 32,
    parameter bit MSB_FIRST  = 0
) (
    input  logic                              clk,
    input  logic                              resetn,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic                              in_bit,
    input  logic                              in_last,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [DATA_WIDTH-1:0]             out_data,
    output logic [$clog2(DATA_WIDTH+1)-1:0]   out_len
);
    localparam int CW = $clog2(DATA_WIDTH);
    localparam int LW = $clog2(DATA_WIDTH+1);

    logic [CW-1:0]         cnt;
    logic [CW-1:0]         pos;
    logic [DATA_WIDTH-1:0] asm_word;
    logic [DATA_WIDTH-1:0] merged;
    logic                  end_bit;
    logic                  accept;
    logic                  complete;

    // Only a word-ending bit can collide with a held, unconsumed output.
    assign end_bit  = (cnt == CW'(DATA_WIDTH-1)) || (in_valid && in_last);
    assign in_ready = !(out_valid && !out_ready && end_bit);
    assign accept   = in_valid && in_ready;
    assign complete = accept && end_bit;
    assign pos      = MSB_FIRST ? CW'(DATA_WIDTH-1) - cnt : cnt;

    always_comb begin
        merged      = asm_word;
        merged[pos] = in_bit;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt       <= '0;
            asm_word  <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_len   <= '0;
        end else if (complete) begin
            out_data  <= merged;
            out_len   <= LW'(cnt) + LW'(1);
            out_valid <= 1'b1;
            cnt       <= '0;
            asm_word  <= '0;
        end else begin
            if (out_ready)
                out_valid <= 1'b0;
            if (accept) begin
                cnt      <= cnt + CW'(1);
                asm_word <= merged;
            end
        end
    end
endmodule

// File: tb/tb_serial_word_deserializer.sv
// tb_serial_word_deserializer: two 8-bit instances (LSB-first and MSB-first) driven with directed tables,
// hand-written corner sequences and random traffic, all checked against a bit-queue reference model.
module tb_serial_word_deserializer;
    logic       clk = 0, resetn = 0;
    logic       in_valid = 0, in_bit = 0, in_last = 0, out_ready = 0;
    logic       in_ready0, in_ready1, out_valid0, out_valid1;
    logic [7:0] out_data0, out_data1;
    logic [3:0] out_len0, out_len1;
    int         errors = 0, checks = 0;

    serial_word_deserializer #(.DATA_WIDTH(8), .MSB_FIRST(0)) dut0 (
        .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready0), .in_bit(in_bit),
        .in_last(in_last), .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0), .out_len(out_len0));
    serial_word_deserializer #(.DATA_WIDTH(8), .MSB_FIRST(1)) dut1 (
        .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready1), .in_bit(in_bit),
        .in_last(in_last), .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1), .out_len(out_len1));

    always #5 clk = ~clk;

    // Reference model: bits of the word in progress, plus the word currently offered downstream.
    bit         bits[$];
    logic       m_valid = 0, m_rdy = 1;
    logic [7:0] m_d0 = 0, m_d1 = 0;
    logic [3:0] m_len = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        bits.delete();
        m_valid = 0; m_d0 = 0; m_d1 = 0; m_len = 0;
    endtask

    task automatic step(input logic v, input logic b, input logic l, input logic r);
        logic       acc, done;
        logic [7:0] w0, w1;
        @(negedge clk);
        in_valid = v; in_bit = b; in_last = l; out_ready = r;
        #1;
        m_rdy = !(m_valid && !r && (bits.size() == 7 || (v && l)));
        chk("in_ready0", in_ready0, m_rdy);
        chk("in_ready1", in_ready1, m_rdy);
        chk("out_valid0", out_valid0, m_valid);
        chk("out_valid1", out_valid1, m_valid);
        chk("out_data0", out_data0, m_d0);
        chk("out_data1", out_data1, m_d1);
        chk("out_len0", out_len0, m_len);
        chk("out_len1", out_len1, m_len);
        acc  = v && m_rdy;
        done = acc && (bits.size() == 7 || l);
        if (acc) bits.push_back(b);
        if (done) begin
            w0 = 0; w1 = 0;
            foreach (bits[i]) begin
                w0[i]     = bits[i];
                w1[7 - i] = bits[i];
            end
            m_d0 = w0; m_d1 = w1; m_len = 4'(bits.size()); m_valid = 1;
            bits.delete();
        end else if (r) begin
            m_valid = 0;
        end
    endtask

    task automatic send_word(input logic [7:0] w, input int n, input logic last, input logic r);
        for (int i = 0; i < n; i++) step(1, w[i], last && i == n - 1, r);
    endtask

    typedef struct {
        int         n;
        logic [7:0] bits_in;
        logic       last;
        logic [7:0] exp0;
        logic [7:0] exp1;
        logic [3:0] exp_len;
    } vec_t;
    vec_t vecs[5];

    int   ov_count;
    logic hold;
    logic rv, rb, rl, rr;

    initial begin
        // bits_in bit i is the i-th bit sent on the serial line.
        vecs[0] = '{8, 8'h81, 1'b0, 8'h81, 8'h81, 4'd8};
        vecs[1] = '{8, 8'h03, 1'b0, 8'h03, 8'hC0, 4'd8};
        vecs[2] = '{3, 8'h07, 1'b1, 8'h07, 8'hE0, 4'd3};
        vecs[3] = '{8, 8'h1E, 1'b0, 8'h1E, 8'h78, 4'd8};
        vecs[4] = '{5, 8'h0D, 1'b1, 8'h0D, 8'hB0, 4'd5};

        #7;
        chk("reset out_valid0", out_valid0, 0);
        chk("reset out_data0", out_data0, 0);
        chk("reset out_len0", out_len0, 0);
        chk("reset in_ready0", in_ready0, 1);
        @(negedge clk); resetn = 1;

        foreach (vecs[k]) begin
            send_word(vecs[k].bits_in, vecs[k].n, vecs[k].last, 1);
            step(0, 0, 0, 1);
            chk("tbl valid", out_valid0, 1);
            chk("tbl data0", out_data0, vecs[k].exp0);
            chk("tbl data1", out_data1, vecs[k].exp1);
            chk("tbl len", out_len0, vecs[k].exp_len);
            step(0, 0, 0, 1);
            chk("tbl one-cycle pulse", out_valid0, 0);
        end

        // Backpressure: the 16th bit stalls until out_ready is raised.
        send_word(8'h96, 8, 0, 0);
        send_word(8'h4B, 7, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(1, 1'b0, 0, 0);
            chk("stall in_ready", in_ready0, 0);
            chk("held data", out_data0, 8'h96);
        end
        step(1, 1'b0, 0, 1);
        chk("release in_ready", in_ready0, 1);
        step(0, 0, 0, 0);
        chk("bp word2 valid", out_valid0, 1);
        chk("bp word2 data", out_data0, 8'h4B);
        chk("bp word2 len", out_len0, 8);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        chk("bp drained", out_valid0, 0);

        // Back-to-back words with out_ready held high.
        ov_count = 0;
        foreach (vecs[k]) if (k < 3) begin
            for (int i = 0; i < 8; i++) begin
                step(1, (k == 0 ? 8'hA5 : k == 1 ? 8'h3C : 8'hFF) >> i, 0, 1);
                chk("stream in_ready", in_ready0, 1);
                ov_count += int'(out_valid0);
            end
        end
        step(0, 0, 0, 1);
        ov_count += int'(out_valid0);
        chk("stream word count", ov_count, 3);
        chk("stream last word", out_data0, 8'hFF);

        // Asynchronous reset mid-word with a held output.
        send_word(8'h11, 8, 0, 0);
        send_word(8'h1F, 5, 0, 0);
        @(negedge clk); #2 resetn = 0; #1;
        chk("abort out_valid", out_valid0, 0);
        chk("abort out_data", out_data0, 0);
        chk("abort out_len", out_len0, 0);
        chk("abort out_data1", out_data1, 0);
        model_reset();
        in_valid = 0;
        @(negedge clk); resetn = 1;
        send_word(8'h5A, 8, 0, 1);
        step(0, 0, 0, 1);
        chk("post-abort data0", out_data0, 8'h5A);
        chk("post-abort data1", out_data1, 8'h5A);
        chk("post-abort len", out_len0, 8);

        // Random traffic; a stalled bit is held stable until accepted.
        hold = 0; rv = 0; rb = 0; rl = 0;
        for (int i = 0; i < 600; i++) begin
            if (!hold) begin
                rv = $urandom_range(0, 3) != 0;
                rb = 1'($urandom);
                rl = $urandom_range(0, 6) == 0;
            end
            rr = $urandom_range(0, 2) != 0;
            step(rv, rb, rl, rr);
            hold = rv && !m_rdy;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
